// File: rtl/pulse_measure.sv
// pulse_measure: measures the high and low run lengths of a serial level and
// reports each completed (high, low) period with a one-cycle valid strobe,
// a saturation flag, a wrapping period count and a repeat-lock indication.
module pulse_measure #(
  parameter int W    = 4,
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din,
  output logic [W-1:0]    hi_len,
  output logic [W-1:0]    lo_len,
  output logic            valid,
  output logic            ovf,
  output logic            locked,
  output logic [PC_W-1:0] periods
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  localparam logic [W-1:0]    CNT_MAX = '1;
  localparam logic [W-1:0]    CNT_ONE = W'(1);
  localparam logic [PC_W-1:0] PER_ONE = PC_W'(1);

  state_t         state;
  logic [W-1:0]   hcnt;
  logic [W-1:0]   lcnt;
  logic           sat;        // sticky: an increment was attempted at CNT_MAX
  logic           have_prev;  // at least one period reported since reset

  // Saturating increment: counters stop at all-ones and never wrap.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  function automatic logic at_max(input logic [W-1:0] c);
    return (c == CNT_MAX);
  endfunction

  // Run-length FSM with registered report outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      hcnt      <= '0;
      lcnt      <= '0;
      sat       <= 1'b0;
      have_prev <= 1'b0;
      hi_len    <= '0;
      lo_len    <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      locked    <= 1'b0;
      periods   <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        // Discard any high run already in progress when reset released.
        IDLE: begin
          if (!din) state <= ARM;
        end
        ARM: begin
          if (din) begin
            state <= HIGH;
            hcnt  <= CNT_ONE;
            sat   <= 1'b0;
          end
        end
        HIGH: begin
          if (din) begin
            hcnt <= sat_inc(hcnt);
            if (at_max(hcnt)) sat <= 1'b1;
          end else begin
            state <= LOW;
            lcnt  <= CNT_ONE;
          end
        end
        LOW: begin
          if (!din) begin
            lcnt <= sat_inc(lcnt);
            if (at_max(lcnt)) sat <= 1'b1;
          end else begin
            // Rising edge closes the period: report it and start the next high run.
            hi_len    <= hcnt;
            lo_len    <= lcnt;
            ovf       <= sat;
            valid     <= 1'b1;
            periods   <= periods + PER_ONE;
            // hi_len/lo_len/ovf still hold the previous report here.
            locked    <= have_prev && (hcnt == hi_len) && (lcnt == lo_len)
                         && !sat && !ovf;
            have_prev <= 1'b1;
            state     <= HIGH;
            hcnt      <= CNT_ONE;
            lcnt      <= '0;
            sat       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_measure.sv
// tb_pulse_measure: directed stimulus for pulse_measure with a queue of
// hand-computed expected reports checked whenever valid is seen.
module tb_pulse_measure;

  localparam int W    = 4;
  localparam int PC_W = 8;

  logic            clk;
  logic            rst;
  logic            din;
  logic [W-1:0]    hi_len;
  logic [W-1:0]    lo_len;
  logic            valid;
  logic            ovf;
  logic            locked;
  logic [PC_W-1:0] periods;

  pulse_measure #(.W(W), .PC_W(PC_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .hi_len  (hi_len),
    .lo_len  (lo_len),
    .valid   (valid),
    .ovf     (ovf),
    .locked  (locked),
    .periods (periods)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int lo;
    int ov;
    int lk;
    int per;
    int gap;   // expected cycles since previous valid; 0 = not checked
  } rep_t;

  rep_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic exp_push(input int h, input int l, input int o, input int k,
                          input int p, input int g);
    rep_t r;
    r.hi = h; r.lo = l; r.ov = o; r.lk = k; r.per = p; r.gap = g;
    expq.push_back(r);
  endtask

  // Apply level lvl for n sampling edges.
  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din = lvl;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hi"},      int'(hi_len),  0);
    check({tag, "_lo"},      int'(lo_len),  0);
    check({tag, "_valid"},   int'(valid),   0);
    check({tag, "_ovf"},     int'(ovf),     0);
    check({tag, "_locked"},  int'(locked),  0);
    check({tag, "_periods"}, int'(periods), 0);
  endtask

  // Hold reset for two edges with din low, checking outputs clear at once.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    din = 1'b0;
    #1;
    check_zero({tag, "_now"});
    repeat (2) @(posedge clk);
    #1;
    check_zero({tag, "_held"});
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compare every valid strobe against the next expected report.
  int   cyc = 0;
  int   last_vcyc = 0;
  logic prev_valid = 1'b0;
  initial begin : monitor
    rep_t r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid) begin
        check("valid_back_to_back", int'(prev_valid), 0);
        if (expq.size() == 0) begin
          check("unexpected_valid", int'(valid), 0);
        end else begin
          r = expq.pop_front();
          check($sformatf("p%0d_hi_len", r.per),  int'(hi_len),  r.hi);
          check($sformatf("p%0d_lo_len", r.per),  int'(lo_len),  r.lo);
          check($sformatf("p%0d_ovf", r.per),     int'(ovf),     r.ov);
          check($sformatf("p%0d_locked", r.per),  int'(locked),  r.lk);
          check($sformatf("p%0d_periods", r.per), int'(periods), r.per);
          if (r.gap != 0) check($sformatf("p%0d_gap", r.per), cyc - last_vcyc, r.gap);
        end
        last_vcyc = cyc;
      end
      prev_valid = valid;
    end
  end

  initial begin : stim
    rst = 1'b0;
    din = 1'b1;
    #3;
    check_zero("reset_init");
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst = 1'b1;

    // 5/3 released with din high: partial run discarded, lock from report 2.
    exp_push(5, 3, 0, 0, 1, 0);
    exp_push(5, 3, 0, 1, 2, 8);
    exp_push(5, 3, 0, 1, 3, 8);
    exp_push(5, 3, 0, 1, 4, 8);
    drive(1'b1, 3);
    drive(1'b0, 3);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5);
      drive(1'b0, 3);
    end

    // Alternating 1/0: single-cycle runs.
    exp_push(1, 1, 0, 0, 5, 2);
    for (int p = 6; p <= 10; p++) exp_push(1, 1, 0, 1, p, 2);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end

    // Saturated 20-cycle high run, then two clean 5/3 periods.
    exp_push(15, 2, 1, 0, 11, 22);
    exp_push(5, 3, 0, 0, 12, 8);
    exp_push(5, 3, 0, 1, 13, 8);
    drive(1'b1, 20);
    drive(1'b0, 2);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5);
      drive(1'b0, 3);
    end

    // Period change 5/3 -> 2/6 while locked.
    exp_push(2, 6, 0, 0, 14, 8);
    exp_push(2, 6, 0, 1, 15, 8);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2);
      drive(1'b0, 6);
    end

    // Reset in the middle of a low run, then one full 5/3 period.
    drive(1'b1, 2);
    drive(1'b0, 2);
    pulse_reset("reset_mid_low");
    exp_push(5, 3, 0, 0, 1, 0);
    drive(1'b0, 1);
    drive(1'b1, 5);
    drive(1'b0, 3);
    drive(1'b1, 5);
    drive(1'b0, 3);

    // 260 periods of 2/2 from reset: period count wraps, lock holds.
    pulse_reset("reset_pre_wrap");
    exp_push(2, 2, 0, 0, 1, 0);
    for (int k = 2; k <= 260; k++) exp_push(2, 2, 0, 1, k % 256, 4);
    drive(1'b0, 1);
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 2);
      drive(1'b0, 2);
    end

    // Constant high: no further reports, outputs hold.
    drive(1'b1, 30);
    @(posedge clk);
    #2;
    check("final_periods", int'(periods), 4);
    check("final_locked",  int'(locked),  1);
    check("final_hi_len",  int'(hi_len),  2);
    check("final_lo_len",  int'(lo_len),  2);
    check("final_valid",   int'(valid),   0);
    check("reports_left",  expq.size(),   0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
